// File: rtl/gb_mapper_pkg.sv
// gb_mapper_pkg: shared constants, region codes and the address-region decoder
// for the Game Boy cartridge bank controller.
package gb_mapper_pkg;

  localparam int MBC1 = 1;
  localparam int MBC5 = 5;

  localparam logic [3:0] RAM_KEY = 4'hA;

  localparam logic [15:0] BASE_ROMB_LO = 16'h2000;
  localparam logic [15:0] BASE_ROMB_HI = 16'h3000;
  localparam logic [15:0] BASE_RAMB    = 16'h4000;
  localparam logic [15:0] BASE_MODE    = 16'h6000;
  localparam logic [15:0] BASE_VRAM    = 16'h8000;
  localparam logic [15:0] BASE_XRAM    = 16'hA000;
  localparam logic [15:0] BASE_HIGH    = 16'hC000;

  typedef enum logic [2:0] {
    RG_RAMEN,
    RG_ROMB_LO,
    RG_ROMB_HI,
    RG_RAMB,
    RG_MODE,
    RG_VRAM,
    RG_XRAM,
    RG_HIGH
  } region_e;

  function automatic region_e decode_region(input logic [15:0] a);
    if (a < BASE_ROMB_LO)      return RG_RAMEN;
    else if (a < BASE_ROMB_HI) return RG_ROMB_LO;
    else if (a < BASE_RAMB)    return RG_ROMB_HI;
    else if (a < BASE_MODE)    return RG_RAMB;
    else if (a < BASE_VRAM)    return RG_MODE;
    else if (a < BASE_XRAM)    return RG_VRAM;
    else if (a < BASE_HIGH)    return RG_XRAM;
    else                       return RG_HIGH;
  endfunction

endpackage

// File: rtl/gb_mapper_sync_if.sv
// gb_mapper_sync_if: Game Boy cartridge bus as seen by the cartridge.
//   GB_ADDR/GB_DIN/GB_WR_N/GB_RD_N/GB_CS_N : driven by the GB CPU
//   GB_DOUT/GB_DOE                         : driven by the cartridge
// master = CPU side, slave = cartridge controller.
interface gb_mapper_sync_if;
  logic [15:0] GB_ADDR;
  logic [7:0]  GB_DIN;
  logic [7:0]  GB_DOUT;
  logic        GB_DOE;
  logic        GB_WR_N;
  logic        GB_RD_N;
  logic        GB_CS_N;

  modport master (
    output GB_ADDR, GB_DIN, GB_WR_N, GB_RD_N, GB_CS_N,
    input  GB_DOUT, GB_DOE
  );

  modport slave (
    input  GB_ADDR, GB_DIN, GB_WR_N, GB_RD_N, GB_CS_N,
    output GB_DOUT, GB_DOE
  );
endinterface

// File: rtl/gb_bus_sync.sv
// gb_bus_sync: brings the asynchronous GB strobes into the board clock domain.
//   clk, rst          : board clock, synchronous active-high reset
//   wr_n/rd_n/cs_n_pin: raw strobes;  addr_pin/data_pin: raw bus
//   wr_n/rd_n/cs_n    : 2-FF synchronised strobes (reset to 1)
//   commit            : one-cycle pulse on a synchronised WR_N rising edge
//   cap_addr/cap_data : bus captured while the synchronised WR_N is low
module gb_bus_sync (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_n_pin,
  input  logic        rd_n_pin,
  input  logic        cs_n_pin,
  input  logic [15:0] addr_pin,
  input  logic [7:0]  data_pin,
  output logic        wr_n,
  output logic        rd_n,
  output logic        cs_n,
  output logic        commit,
  output logic [15:0] cap_addr,
  output logic [7:0]  cap_data
);

  logic       wr_s1, rd_s1, cs_s1;
  logic       wr_s2, rd_s2, cs_s2;
  logic       wr_prev;
  logic [2:0] vld;
  logic       armed;
  logic       fall, rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_s1    <= 1'b1;
      rd_s1    <= 1'b1;
      cs_s1    <= 1'b1;
      wr_s2    <= 1'b1;
      rd_s2    <= 1'b1;
      cs_s2    <= 1'b1;
      wr_prev  <= 1'b1;
      vld      <= '0;
      armed    <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
    end else begin
      wr_s1   <= wr_n_pin;
      rd_s1   <= rd_n_pin;
      cs_s1   <= cs_n_pin;
      wr_s2   <= wr_s1;
      rd_s2   <= rd_s1;
      cs_s2   <= cs_s1;
      wr_prev <= wr_s2;
      vld     <= {vld[1:0], 1'b1};
      if (!wr_s2) begin
        cap_addr <= addr_pin;
        cap_data <= data_pin;
      end
      if (fall)
        armed <= 1'b1;
      else if (rise)
        armed <= 1'b0;
    end
  end

  // The reset value 1 of the sync chain is artificial; a falling edge only
  // counts once wr_s2 and wr_prev both hold real pin samples (3 CLK after
  // reset), so a write already low at reset release never arms a commit.
  assign fall   = vld[2] & wr_prev & ~wr_s2;
  assign rise   = ~wr_prev & wr_s2;
  assign commit = rise & armed;

  assign wr_n = wr_s2;
  assign rd_n = rd_s2;
  assign cs_n = cs_s2;

endmodule

// File: rtl/gb_mapper_sync.sv
// gb_mapper_sync: synchronous MBC1/MBC5 cartridge bank controller.
//   CLK, RST         : board clock (>= 8x bus rate), synchronous active-high reset
//   gb               : cartridge bus (slave modport)
//   ROM_ADDR/ROM_DQ  : flash address / read data
//   RAM_ADDR/RAM_DIN/RAM_DOUT/RAM_WE : SRAM address, read data, write data, 1-CLK write pulse
//   RAM_EN_Q, ROM_BANK_Q, RAM_BANK_Q : status (RAM enabled, bank at 0x4000, RAM bank)
module gb_mapper_sync
  import gb_mapper_pkg::*;
#(
  parameter  int MAPPER = 1,
  parameter  int ROM_AW = 22,
  parameter  int RAM_AW = 15,
  localparam int RBW    = ROM_AW - 14,
  // RAM_AW = 13 means no bank bits; keep a 1-bit status port in that case
  localparam int ABW    = (RAM_AW > 13) ? (RAM_AW - 13) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  gb_mapper_sync_if.slave   gb,
  output logic [ROM_AW-1:0] ROM_ADDR,
  input  logic [7:0]        ROM_DQ,
  output logic [RAM_AW-1:0] RAM_ADDR,
  input  logic [7:0]        RAM_DIN,
  output logic [7:0]        RAM_DOUT,
  output logic              RAM_WE,
  output logic              RAM_EN_Q,
  output logic [RBW-1:0]    ROM_BANK_Q,
  output logic [ABW-1:0]    RAM_BANK_Q
);

  if (MAPPER != MBC1 && MAPPER != MBC5) begin : g_bad_mapper
    $error("gb_mapper_sync: MAPPER must be 1 or 5");
  end
  if (ROM_AW < 15 || ROM_AW > 23) begin : g_bad_rom_aw
    $error("gb_mapper_sync: ROM_AW must be 15..23");
  end
  if (RAM_AW < 13 || RAM_AW > 17) begin : g_bad_ram_aw
    $error("gb_mapper_sync: RAM_AW must be 13..17");
  end

  logic        wr_n_s, rd_n_s, cs_n_s;
  logic        commit;
  logic [15:0] cap_addr;
  logic [7:0]  cap_data;

  gb_bus_sync u_sync (
    .clk      (CLK),
    .rst      (RST),
    .wr_n_pin (gb.GB_WR_N),
    .rd_n_pin (gb.GB_RD_N),
    .cs_n_pin (gb.GB_CS_N),
    .addr_pin (gb.GB_ADDR),
    .data_pin (gb.GB_DIN),
    .wr_n     (wr_n_s),
    .rd_n     (rd_n_s),
    .cs_n     (cs_n_s),
    .commit   (commit),
    .cap_addr (cap_addr),
    .cap_data (cap_data)
  );

  logic       ram_en;
  logic [4:0] bank1;
  logic [1:0] bank2;
  logic       mode;
  logic [8:0] romb;
  logic [3:0] ramb;
  logic       ram_we;
  region_e    cap_rg, bus_rg;

  assign cap_rg = decode_region(cap_addr);
  assign bus_rg = decode_region(gb.GB_ADDR);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ram_en <= 1'b0;
      bank1  <= '0;
      bank2  <= '0;
      mode   <= 1'b0;
      romb   <= 9'd1;
      ramb   <= '0;
      ram_we <= 1'b0;
    end else begin
      ram_we <= commit && (cap_rg == RG_XRAM) && ram_en;
      if (commit) begin
        case (cap_rg)
          RG_RAMEN:   ram_en <= (cap_data[3:0] == RAM_KEY);
          RG_ROMB_LO: if (MAPPER == MBC1) bank1 <= cap_data[4:0];
                      else                romb[7:0] <= cap_data;
          RG_ROMB_HI: if (MAPPER == MBC1) bank1 <= cap_data[4:0];
                      else                romb[8] <= cap_data[0];
          RG_RAMB:    if (MAPPER == MBC1) bank2 <= cap_data[1:0];
                      else                ramb <= cap_data[3:0];
          RG_MODE:    if (MAPPER == MBC1) mode <= cap_data[0];
          default:    ;
        endcase
      end
    end
  end

  logic [RBW-1:0] bank_hi, bank_lo;
  logic [ABW-1:0] ram_bank;
  logic [12:0]    ram_a;

  always_comb begin
    if (MAPPER == MBC1) begin
      bank_hi  = RBW'({bank2, (bank1 == 5'd0) ? 5'd1 : bank1});
      bank_lo  = mode ? RBW'({bank2, 5'd0}) : '0;
      ram_bank = mode ? ABW'(bank2) : '0;
    end else begin
      bank_hi  = RBW'(romb);
      bank_lo  = '0;
      ram_bank = ABW'(ramb);
    end
  end

  assign ROM_ADDR = {gb.GB_ADDR[14] ? bank_hi : bank_lo, gb.GB_ADDR[13:0]};

  // The write pulse comes after WR_N has risen, when the live bus may have
  // moved on, so the SRAM address is taken from the captured one.
  assign ram_a = ram_we ? cap_addr[12:0] : gb.GB_ADDR[12:0];

  if (RAM_AW > 13) begin : g_ram_banked
    assign RAM_ADDR = {ram_bank, ram_a};
  end else begin : g_ram_flat
    assign RAM_ADDR = ram_a;
  end

  assign RAM_DOUT = cap_data;
  assign RAM_WE   = ram_we;

  logic rom_rd, ram_rd;
  assign rom_rd = ~gb.GB_ADDR[15];
  assign ram_rd = (bus_rg == RG_XRAM) && !cs_n_s && ram_en;

  assign gb.GB_DOE  = !rd_n_s && wr_n_s && (rom_rd || ram_rd);
  assign gb.GB_DOUT = rom_rd ? ROM_DQ : RAM_DIN;

  assign RAM_EN_Q   = ram_en;
  assign ROM_BANK_Q = bank_hi;
  assign RAM_BANK_Q = ram_bank;

endmodule

// File: tb/tb_gb_mapper_sync.sv
// tb_gb_mapper_sync: MBC1 and MBC5 instances driven from one shared bus.
// Expected SRAM writes are queued per instance when a write is driven and
// popped by a monitor whenever RAM_WE pulses; register and read-path results
// are compared against constants.
module tb_gb_mapper_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        wr_n, rd_n, cs_n;

  always #5 clk = ~clk;

  gb_mapper_sync_if bus1 ();
  gb_mapper_sync_if bus5 ();

  assign bus1.GB_ADDR = addr;
  assign bus1.GB_DIN  = din;
  assign bus1.GB_WR_N = wr_n;
  assign bus1.GB_RD_N = rd_n;
  assign bus1.GB_CS_N = cs_n;
  assign bus5.GB_ADDR = addr;
  assign bus5.GB_DIN  = din;
  assign bus5.GB_WR_N = wr_n;
  assign bus5.GB_RD_N = rd_n;
  assign bus5.GB_CS_N = cs_n;

  logic [21:0] rom_addr1, rom_addr5;
  logic [7:0]  rom_dq1, rom_dq5;
  logic [14:0] ram_addr1, ram_addr5;
  logic [7:0]  ram_din1, ram_din5, ram_dout1, ram_dout5;
  logic        ram_we1, ram_we5, ram_en_q1, ram_en_q5;
  logic [7:0]  rom_bank_q1, rom_bank_q5;
  logic [1:0]  ram_bank_q1, ram_bank_q5;

  // simple memory models: data is a fixed function of the address
  assign rom_dq1  = rom_addr1[7:0] ^ 8'h5C;
  assign rom_dq5  = rom_addr5[7:0] ^ 8'h5C;
  assign ram_din1 = ram_addr1[7:0] ^ 8'hA5;
  assign ram_din5 = ram_addr5[7:0] ^ 8'hA5;

  gb_mapper_sync #(.MAPPER(1), .ROM_AW(22), .RAM_AW(15)) dut1 (
    .CLK(clk), .RST(rst), .gb(bus1),
    .ROM_ADDR(rom_addr1), .ROM_DQ(rom_dq1),
    .RAM_ADDR(ram_addr1), .RAM_DIN(ram_din1), .RAM_DOUT(ram_dout1), .RAM_WE(ram_we1),
    .RAM_EN_Q(ram_en_q1), .ROM_BANK_Q(rom_bank_q1), .RAM_BANK_Q(ram_bank_q1)
  );

  gb_mapper_sync #(.MAPPER(5), .ROM_AW(22), .RAM_AW(15)) dut5 (
    .CLK(clk), .RST(rst), .gb(bus5),
    .ROM_ADDR(rom_addr5), .ROM_DQ(rom_dq5),
    .RAM_ADDR(ram_addr5), .RAM_DIN(ram_din5), .RAM_DOUT(ram_dout5), .RAM_WE(ram_we5),
    .RAM_EN_Q(ram_en_q5), .ROM_BANK_Q(rom_bank_q5), .RAM_BANK_Q(ram_bank_q5)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [14:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t q1[$];
  wr_t q5[$];
  wr_t e1, e5;

  always @(negedge clk) begin
    if (ram_we1) begin
      if (q1.size() == 0) chk("we1_spurious", 32'(ram_we1), 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("we1_addr", 32'(ram_addr1), 32'(e1.a));
        chk("we1_data", 32'(ram_dout1), 32'(e1.d));
      end
    end
    if (ram_we5) begin
      if (q5.size() == 0) chk("we5_spurious", 32'(ram_we5), 32'd0);
      else begin
        e5 = q5.pop_front();
        chk("we5_addr", 32'(ram_addr5), 32'(e5.a));
        chk("we5_data", 32'(ram_dout5), 32'(e5.d));
      end
    end
  end

  task automatic push_we(input logic [14:0] a, input logic [7:0] d);
    q1.push_back({a, d});
    q5.push_back({a, d});
  endtask

  // one write cycle: WR_N low for lo CLK; bus address moves away once the
  // capture window has closed so the pulse must use the captured address
  task automatic wr_cyc(input logic [15:0] a, input logic [7:0] d, input int lo,
                        input bit exp_we, input logic [14:0] exp_a);
    @(posedge clk); #1;
    addr = a; din = d; wr_n = 1'b0;
    if (exp_we) push_we(exp_a, d);
    repeat (lo) @(posedge clk);
    #1 wr_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 addr = 16'h7FFF; din = 8'hEE;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    wr_cyc(a, d, 4, 1'b0, 15'd0);
  endtask

  // two writes to one address separated by exactly 2 CLK of WR_N high
  task automatic wr_pair(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1,
                         input bit exp_we, input logic [14:0] exp_a);
    @(posedge clk); #1;
    addr = a; din = d0; wr_n = 1'b0;
    if (exp_we) push_we(exp_a, d0);
    repeat (3) @(posedge clk);
    #1 wr_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 din = d1; wr_n = 1'b0;
    if (exp_we) push_we(exp_a, d1);
    repeat (3) @(posedge clk);
    #1 wr_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
  endtask

  task automatic rd_begin(input logic [15:0] a, input logic cs);
    @(posedge clk); #1;
    addr = a; cs_n = cs; rd_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd_end();
    @(posedge clk); #1;
    rd_n = 1'b1; cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; addr = '0; din = '0; wr_n = 1'b1; rd_n = 1'b1; cs_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);

    chk("rst_doe1", 32'(bus1.GB_DOE), 0);
    chk("rst_we1", 32'(ram_we1), 0);
    chk("rst_ramen1", 32'(ram_en_q1), 0);
    chk("rst_rombank1", 32'(rom_bank_q1), 1);
    chk("rst_rombank5", 32'(rom_bank_q5), 1);
    chk("rst_rambank1", 32'(ram_bank_q1), 0);
    chk("rst_rambank5", 32'(ram_bank_q5), 0);

    rd_begin(16'h4000, 1'b1);
    chk("rd4000_addr1", 32'(rom_addr1), 32'h004000);
    chk("rd4000_doe1", 32'(bus1.GB_DOE), 1);
    chk("rd4000_dout1", 32'(bus1.GB_DOUT), 32'h5C);
    chk("rd4000_addr5", 32'(rom_addr5), 32'h004000);
    chk("rd4000_doe5", 32'(bus5.GB_DOE), 1);
    rd_end();
    chk("rd_release_doe1", 32'(bus1.GB_DOE), 0);

    // MBC1 bank1=0 -> 1, bank2=2; MBC5 romb=0, ramb=2
    wr(16'h2000, 8'h00);
    wr(16'h4000, 8'h02);
    rd_begin(16'h4123, 1'b1);
    chk("rd4123_addr1", 32'(rom_addr1), 32'h104123);
    chk("rd4123_dout1", 32'(bus1.GB_DOUT), 32'h7F);
    chk("rd4123_addr5", 32'(rom_addr5), 32'h000123);
    rd_end();
    chk("bank_q1_41", 32'(rom_bank_q1), 32'h41);
    chk("bank_q5_00", 32'(rom_bank_q5), 32'h00);

    wr(16'h6000, 8'h01);
    rd_begin(16'h0123, 1'b1);
    chk("rd0123_addr1", 32'(rom_addr1), 32'h100123);
    chk("rd0123_addr5", 32'(rom_addr5), 32'h000123);
    rd_end();
    chk("rambank1_mode", 32'(ram_bank_q1), 2);
    chk("rambank5", 32'(ram_bank_q5), 2);

    // MBC5 bit 8 set: 0x100 truncates to 0 with 8 bank bits
    wr(16'h3000, 8'h01);
    rd_begin(16'h4000, 1'b1);
    chk("trunc_addr5", 32'(rom_addr5), 32'h000000);
    chk("b1_3000_addr1", 32'(rom_addr1), 32'h104000);
    rd_end();
    wr(16'h2000, 8'h05);
    rd_begin(16'h4000, 1'b1);
    chk("wrap_addr5", 32'(rom_addr5), 32'h014000);
    chk("b1_5_addr1", 32'(rom_addr1), 32'h114000);
    rd_end();

    wr(16'h4000, 8'h00);
    chk("bank_q1_05", 32'(rom_bank_q1), 32'h05);
    chk("rambank1_zero", 32'(ram_bank_q1), 0);

    // RAM enable and write
    wr(16'h0000, 8'h0A);
    chk("ramen1_on", 32'(ram_en_q1), 1);
    chk("ramen5_on", 32'(ram_en_q5), 1);
    wr_cyc(16'hA010, 8'h5A, 4, 1'b1, 15'h0010);
    rd_begin(16'hA010, 1'b0);
    chk("ramrd_doe1", 32'(bus1.GB_DOE), 1);
    chk("ramrd_dout1", 32'(bus1.GB_DOUT), 32'hB5);
    chk("ramrd_doe5", 32'(bus5.GB_DOE), 1);
    rd_end();
    rd_begin(16'hA010, 1'b1);
    chk("ramrd_nocs_doe1", 32'(bus1.GB_DOE), 0);
    rd_end();

    wr(16'h0000, 8'h00);
    chk("ramen1_off", 32'(ram_en_q1), 0);
    wr_cyc(16'hA010, 8'h5A, 4, 1'b0, 15'h0010);
    rd_begin(16'hA010, 1'b0);
    chk("ramoff_doe1", 32'(bus1.GB_DOE), 0);
    chk("ramoff_doe5", 32'(bus5.GB_DOE), 0);
    rd_end();

    // region boundaries
    wr(16'h8000, 8'h0A);
    wr(16'hC000, 8'h0A);
    chk("vram_hi_ramen1", 32'(ram_en_q1), 0);
    chk("vram_hi_ramen5", 32'(ram_en_q5), 0);
    chk("vram_hi_bank1", 32'(rom_bank_q1), 32'h05);
    wr(16'h1FFF, 8'h1A);
    chk("key_1fff_on1", 32'(ram_en_q1), 1);
    wr(16'h1FFF, 8'h0B);
    chk("key_1fff_off5", 32'(ram_en_q5), 0);

    // reset while a write is in progress
    @(posedge clk); #1;
    addr = 16'h0000; din = 8'h0A; wr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 wr_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("midrst_ramen1", 32'(ram_en_q1), 0);
    chk("midrst_ramen5", 32'(ram_en_q5), 0);
    chk("midrst_bank1", 32'(rom_bank_q1), 1);
    chk("midrst_bank5", 32'(rom_bank_q5), 1);

    // glitch and minimum spacing
    wr(16'h0000, 8'h0A);
    wr_cyc(16'hA020, 8'h33, 1, 1'b1, 15'h0020);
    wr_pair(16'hA030, 8'h11, 8'h22, 1'b1, 15'h0030);
    wr_pair(16'h2000, 8'h03, 8'h07, 1'b0, 15'h0000);
    chk("pair_bank1", 32'(rom_bank_q1), 32'h07);
    chk("pair_bank5", 32'(rom_bank_q5), 32'h07);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q5_drained", 32'(q5.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
